pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses, such as strobes from the button shaping logic or game events, into sustained level outputs held for a fixed number of cycles.
- Drives LEDs and the beeper in the bomb-defuse game.
- Pulses that arrive while an output period is active are queued and replayed in order, separated by a fixed gap.
- Sits between event-generating logic and the external indicator pins.

Parameters:
- ON_CYCLES, 50: cycles s_out is held active per accepted pulse; must be >= 1.
- GAP_CYCLES, 25: inactive cycles between consecutive replayed periods; 0 is allowed.
- PEND_MAX, 7: maximum number of queued pulses; must be >= 1.
- CNT_W, 16: width of the period counter; must hold max(ON_CYCLES, GAP_CYCLES).
- PEND_W, 3: width of the pending counter; must hold PEND_MAX.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Rst  input  1  reset, asynchronous, active-low.
- p_in  input  1  event pulse; each high cycle counts as one event.
- clr  input  1  synchronous flush; high for one or more cycles.
- s_out  output  1  stretched level output, registered.
- busy  output  1  high while in S_ON or S_GAP, registered.
- pending  output  PEND_W  number of queued events not yet played.
- overflow  output  1  one-cycle pulse when an event is dropped because the queue is full.

Behaviour:
- Clocking and reset: one clock, Clk. Reset is asynchronous and active-low on Rst (Rst == 0 resets). All state is held in registers.
- Reset values: State = S_IDLE, counter = 0, pending = 0, s_out = 0, busy = 0, overflow = 0. Asserting Rst mid-period forces these values immediately, with no completion of the active period.
- States: S_IDLE, S_ON, S_GAP. Encoding is 2 bits; the unused code returns to S_IDLE.
- S_IDLE:
  - s_out = 0.
  - p_in = 1 -> S_ON, counter loaded with ON_CYCLES-1; pending is unchanged.
  - s_out rises on the edge that samples p_in, so latency is 1 cycle.
- S_ON:
  - s_out = 1; counter decrements each cycle.
  - counter == 0 and GAP_CYCLES > 0 -> S_GAP, counter loaded with GAP_CYCLES-1.
  - counter == 0 and GAP_CYCLES == 0 -> behaves as the end of S_GAP (see below).
  - s_out is high for exactly ON_CYCLES consecutive cycles per event.
- S_GAP:
  - s_out = 0; counter decrements each cycle.
  - At counter == 0: if the pending value after this cycle's update is > 0 -> S_ON, counter reloaded with ON_CYCLES-1, pending decremented. Otherwise -> S_IDLE.
- Queueing:
  - p_in = 1 while in S_ON or S_GAP increments pending, saturating at PEND_MAX.
  - p_in = 1 when pending == PEND_MAX drops the event and asserts overflow on the next cycle for exactly one cycle.
- Simultaneous events:
  - Increment and consume in the same cycle (final gap cycle with p_in = 1) leaves pending unchanged and enters S_ON.
  - If pending == PEND_MAX in that cycle, the arriving event is accepted, not dropped, and overflow stays 0.
- clr:
  - Next state is S_IDLE; pending = 0; s_out = 0 and busy = 0 on the next cycle.
  - clr has priority over p_in in the same cycle; that p_in is discarded without overflow.
- busy = 1 exactly when State is S_ON or S_GAP, as a registered copy of the next state.
- No event is ever lost except by overflow, clr, or reset.

Optional Feature:
- Macro: PULSE_STRETCH_RETRIGGER_EN.
- Defined:
  - p_in = 1 in S_ON reloads the counter with ON_CYCLES-1 (extends the current period) instead of incrementing pending.
  - p_in in S_GAP still queues as normal.
  - overflow can only fire from S_GAP arrivals.
- Undefined: queueing behaviour exactly as described above.

Test Plan (ON_CYCLES=4, GAP_CYCLES=2, PEND_MAX=3):
- Single pulse: Rst low then high; p_in high 1 cycle at edge 0 -> s_out high edges 1-4, low from 5; busy high edges 1-6; S_IDLE at edge 7; pending stays 0.
- Queued pulse: p_in at edge 0 and edge 2 -> pending = 1 after edge 2; s_out high 1-4, low 5-6, high 7-10; pending = 0 at edge 7.
- Overflow: p_in at edge 0, then p_in high 4 cycles during S_ON -> pending saturates at 3; overflow high exactly 1 cycle after the 4th queued attempt; total of 4 ON periods played.
- Simultaneous increment/consume: pending = 3 and p_in high on the final S_GAP cycle -> enters S_ON, pending stays 3, overflow stays 0.
- Flush and reset: clr and p_in high together mid-S_ON with pending = 2 -> next cycle s_out = 0, busy = 0, pending = 0, overflow = 0. Separately, Rst low mid-S_GAP clears all outputs asynchronously, before the next Clk edge.
- Macro defined: p_in at edge 0 and edge 3 -> s_out high edges 1-7 continuously, pending remains 0.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into ON_CYCLES-long levels, queueing overlapping events.
// Optional macro PULSE_STRETCH_RETRIGGER_EN: a pulse during S_ON extends the active period instead of queueing.
module pulse_stretcher #(
    parameter int ON_CYCLES  = 50,
    parameter int GAP_CYCLES = 25,
    parameter int PEND_MAX   = 7,
    parameter int CNT_W      = 16,
    parameter int PEND_W     = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              p_in,
    input  logic              clr,
    output logic              s_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ON   = 2'b01,
        S_GAP  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0]  ON_LOAD   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PEND_W-1:0]   r_pend;
    logic                r_sOut;
    logic                r_busy;
    logic                r_ovf;

    state_t              w_nextState;
    logic [CNT_W-1:0]    w_nextCnt;
    logic [PEND_W-1:0]   w_nextPend;
    logic                w_nextOvf;
    logic                w_queue;
    logic                w_endGap;
    logic [PEND_W:0]     w_pendSum;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextPend  = r_pend;
        w_nextOvf   = 1'b0;
        w_queue     = 1'b0;
        w_endGap    = 1'b0;
        // One bit wider so a full queue plus an arrival does not wrap before the consume.
        w_pendSum   = {1'b0, r_pend} + {{PEND_W{1'b0}}, p_in};

        if (clr) begin
            w_nextState = S_IDLE;
            w_nextCnt   = '0;
            w_nextPend  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (p_in) begin
                        w_nextState = S_ON;
                        w_nextCnt   = ON_LOAD;
                    end
                end
                S_ON: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                    if (p_in) begin
                        w_nextCnt = ON_LOAD;
                    end else if (r_cnt != '0) begin
                        w_nextCnt = r_cnt - CNT_W'(1);
                    end else if (GAP_CYCLES > 0) begin
                        w_nextState = S_GAP;
                        w_nextCnt   = GAP_LOAD;
                    end else begin
                        w_endGap = 1'b1;
                    end
`else
                    if (r_cnt != '0) begin
                        w_nextCnt = r_cnt - CNT_W'(1);
                        w_queue   = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        w_nextState = S_GAP;
                        w_nextCnt   = GAP_LOAD;
                        w_queue     = 1'b1;
                    end else begin
                        w_endGap = 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (r_cnt != '0) begin
                        w_nextCnt = r_cnt - CNT_W'(1);
                        w_queue   = 1'b1;
                    end else begin
                        w_endGap = 1'b1;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                    w_nextCnt   = '0;
                end
            endcase

            if (w_queue && p_in) begin
                if (r_pend == PEND_FULL) begin
                    w_nextOvf = 1'b1;
                end else begin
                    w_nextPend = r_pend + PEND_W'(1);
                end
            end

            // End of a gap: an event arriving this cycle counts before the consume, so it is never dropped.
            if (w_endGap) begin
                if (w_pendSum != '0) begin
                    w_nextState = S_ON;
                    w_nextCnt   = ON_LOAD;
                    w_nextPend  = PEND_W'(w_pendSum - (PEND_W + 1)'(1));
                end else begin
                    w_nextState = S_IDLE;
                    w_nextCnt   = '0;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_sOut  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_pend  <= w_nextPend;
            r_sOut  <= (w_nextState == S_ON);
            r_busy  <= (w_nextState == S_ON) || (w_nextState == S_GAP);
            r_ovf   <= w_nextOvf;
        end
    end

    assign s_out    = r_sOut;
    assign busy     = r_busy;
    assign pending  = r_pend;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher (ON_CYCLES=4, GAP_CYCLES=2, PEND_MAX=3).
// A cycle model pushes expected outputs per driven cycle; they are popped after the clock edge.
module tb_pulse_stretcher;

    localparam int ON_C   = 4;
    localparam int GAP_C  = 2;
    localparam int PMAX   = 3;
    localparam int PEND_W = 2;

    logic              Clk;
    logic              Rst;
    logic              p_in;
    logic              clr;
    logic              s_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    pulse_stretcher #(
        .ON_CYCLES (ON_C),
        .GAP_CYCLES(GAP_C),
        .PEND_MAX  (PMAX),
        .CNT_W     (16),
        .PEND_W    (PEND_W)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .p_in    (p_in),
        .clr     (clr),
        .s_out   (s_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int sOut;
        int busy;
        int pend;
        int ovf;
    } exp_t;

    exp_t sbQ[$];

    int checkCount = 0;
    int failCount  = 0;
    int mState, mCnt, mPend, mOvf;
    int highCount, riseCount, ovfCount;
    int prevSOut;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0; mCnt = 0; mPend = 0; mOvf = 0;
        prevSOut = 0;
    endtask

    task automatic modelEnqueue(input logic p);
        if (p) begin
            if (mPend == PMAX) mOvf = 1;
            else mPend++;
        end
    endtask

    // States: 0 idle, 1 on, 2 gap.
    task automatic modelStep(input logic p, input logic c);
        int after;
        mOvf = 0;
        if (c) begin
            mState = 0; mCnt = 0; mPend = 0;
        end else if (mState == 0) begin
            if (p) begin mState = 1; mCnt = ON_C - 1; end
        end else begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
            if (mState == 1 && p) begin
                mCnt = ON_C - 1;
            end else
`endif
            if (mCnt != 0) begin
                mCnt--;
                modelEnqueue(p);
            end else if (mState == 1 && GAP_C > 0) begin
                mState = 2; mCnt = GAP_C - 1;
                modelEnqueue(p);
            end else begin
                after = mPend + (p ? 1 : 0);
                if (after > 0) begin
                    mState = 1; mCnt = ON_C - 1; mPend = after - 1;
                end else begin
                    mState = 0; mCnt = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic p, input logic c);
        exp_t e;
        p_in = p;
        clr  = c;
        modelStep(p, c);
        e.sOut = (mState == 1) ? 1 : 0;
        e.busy = (mState != 0) ? 1 : 0;
        e.pend = mPend;
        e.ovf  = mOvf;
        sbQ.push_back(e);
        @(posedge Clk);
        #1;
        e = sbQ.pop_front();
        checkOutput("s_out",    int'(s_out),    e.sOut);
        checkOutput("busy",     int'(busy),     e.busy);
        checkOutput("pending",  int'(pending),  e.pend);
        checkOutput("overflow", int'(overflow), e.ovf);
        if (s_out) highCount++;
        if (s_out && prevSOut == 0) riseCount++;
        if (overflow) ovfCount++;
        prevSOut = int'(s_out);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic clearCounters();
        highCount = 0; riseCount = 0; ovfCount = 0;
    endtask

    initial begin
        Rst = 1'b0; p_in = 1'b0; clr = 1'b0;
        modelReset();
        clearCounters();
        #22;
        checkOutput("rst_s_out",    int'(s_out),    0);
        checkOutput("rst_busy",     int'(busy),     0);
        checkOutput("rst_pending",  int'(pending),  0);
        checkOutput("rst_overflow", int'(overflow), 0);
        @(negedge Clk);
        Rst = 1'b1;

        // Single pulse: four high cycles then a two-cycle gap.
        clearCounters();
        applyStimulus(1'b1, 1'b0);
        idleCycles(8);
        checkOutput("single_high_cycles", highCount, ON_C);

        // Queued pulse.
        clearCounters();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idleCycles(12);
        checkOutput("queued_periods", riseCount, 2);

        // Overflow: one start pulse plus four queue attempts.
        clearCounters();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        idleCycles(30);
`ifndef PULSE_STRETCH_RETRIGGER_EN
        checkOutput("ovf_periods", riseCount, 4);
        checkOutput("ovf_pulses", ovfCount, 1);
`endif

        // Arrival on the final gap cycle with a full queue.
        clearCounters();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
`ifndef PULSE_STRETCH_RETRIGGER_EN
        checkOutput("simul_pending", int'(pending), 3);
        checkOutput("simul_s_out",   int'(s_out),   1);
`endif
        checkOutput("simul_overflow", int'(overflow), 0);
        idleCycles(40);

        // clr together with p_in mid-period.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("clr_s_out",    int'(s_out),    0);
        checkOutput("clr_busy",     int'(busy),     0);
        checkOutput("clr_pending",  int'(pending),  0);
        checkOutput("clr_overflow", int'(overflow), 0);
        idleCycles(3);

        // Asynchronous reset during a gap with one event queued.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idleCycles(3);
        checkOutput("pre_rst_busy", int'(busy), 1);
        #2;
        Rst = 1'b0;
        #1;
        checkOutput("arst_s_out",    int'(s_out),    0);
        checkOutput("arst_busy",     int'(busy),     0);
        checkOutput("arst_pending",  int'(pending),  0);
        checkOutput("arst_overflow", int'(overflow), 0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        modelReset();

        // Pulse three cycles after the first: retrigger extends, otherwise queues.
        clearCounters();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idleCycles(14);
`ifdef PULSE_STRETCH_RETRIGGER_EN
        checkOutput("retrig_high_cycles", highCount, 7);
        checkOutput("retrig_periods", riseCount, 1);
`else
        checkOutput("retrig_high_cycles", highCount, 2 * ON_C);
        checkOutput("retrig_periods", riseCount, 2);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        end
        idleCycles(60);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
